// File: rtl/fft_out_reorder_if.sv
// Stream interface for fft_out_reorder: bit-reversed input frames from
// fft_chip, natural-order output frames with framing, bin index and
// resync error flag.
interface fft_out_reorder_if #(
    parameter int DW    = 34,
    parameter int LOG2N = 4
);
    logic             in_valid;
    logic             in_sop;
    logic [DW-1:0]    in_data;
    logic             out_valid;
    logic             out_sop;
    logic [LOG2N-1:0] out_idx;
    logic [DW-1:0]    out_data;
    logic             sop_err;

    modport master (
        output in_valid, in_sop, in_data,
        input  out_valid, out_sop, out_idx, out_data, sop_err
    );

    modport slave (
        input  in_valid, in_sop, in_data,
        output out_valid, out_sop, out_idx, out_data, sop_err
    );
endinterface

// File: rtl/fft_out_reorder.sv
// fft_out_reorder: buffers bit-reversed FFT frames in a ping-pong RAM and
// replays each frame in natural bin order with out_sop and out_idx.
// Optional build macro FFT_OUT_REORDER_SCALE_EN: each 17-bit component of
// out_data is arithmetic-shifted right by LOG2N (IFFT normalisation).
//
// state | meaning
// IDLE  | no full bank at rd_bank; a full bank is read starting this cycle
// READ  | streaming rd_bank, rd_cnt = bin being read this cycle
module fft_out_reorder #(
    parameter int DW    = 34,
    parameter int LOG2N = 4
) (
    input logic              clk,
    input logic              rst_n,
    fft_out_reorder_if.slave bus
);
    localparam int N  = 2 ** LOG2N;
    localparam int CW = DW / 2;

    typedef enum logic {IDLE, READ} state_t;

    state_t           state, state_nxt;
    logic             synced;
    logic [LOG2N-1:0] wr_cnt, wr_cnt_eff, wr_addr;
    logic [LOG2N-1:0] rd_cnt;
    logic             wr_bank, rd_bank;
    logic [1:0]       full, full_set, full_clr;
    logic             wr_en, wr_last, rd_fire, rd_last;
    logic [DW-1:0]    rd_word, rd_out;
    logic [DW-1:0]    mem [0:2*N-1];

    function automatic logic [LOG2N-1:0] bit_rev(input logic [LOG2N-1:0] a);
        bit_rev = '0;
        for (int i = 0; i < LOG2N; i++) bit_rev[i] = a[LOG2N-1-i];
    endfunction

    // Write-side decode: an in_sop restarts the frame at address 0.
    always_comb begin
        wr_en      = bus.in_valid & (synced | bus.in_sop);
        wr_cnt_eff = bus.in_sop ? '0 : wr_cnt;
        wr_addr    = bit_rev(wr_cnt_eff);
        wr_last    = wr_en & (wr_cnt_eff == LOG2N'(N - 1));
        full_set   = {wr_last & wr_bank, wr_last & ~wr_bank};
        full_clr   = {rd_last & rd_bank, rd_last & ~rd_bank};
    end

    // Write counter, bank pointer, sync flag and resync error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            synced      <= 1'b0;
            wr_cnt      <= '0;
            wr_bank     <= 1'b0;
            bus.sop_err <= 1'b0;
        end else begin
            bus.sop_err <= bus.in_valid & bus.in_sop & synced & (wr_cnt != '0);
            if (wr_en) begin
                synced <= 1'b1;
                if (wr_last) begin
                    wr_cnt  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_cnt <= wr_cnt_eff + 1'b1;
                end
            end
        end
    end

    // Ping-pong sample RAM; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[{wr_bank, wr_addr}] <= bus.in_data;
    end

    // Bank-full flags; set and clear never target the same bank on one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) full <= 2'b00;
        else        full <= (full & ~full_clr) | full_set;
    end

    // Read FSM next state: IDLE already reads bin 0 to get 1-cycle turnaround.
    always_comb begin
        state_nxt = state;
        rd_fire   = 1'b0;
        case (state)
            IDLE: begin
                if (full[rd_bank]) begin
                    rd_fire   = 1'b1;
                    state_nxt = READ;
                end
            end
            READ: begin
                rd_fire = 1'b1;
                if ((rd_cnt == LOG2N'(N - 1)) && !full[~rd_bank]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        rd_last = rd_fire & (rd_cnt == LOG2N'(N - 1));
    end

    // Read FSM state, read counter and read bank pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
        end else begin
            state <= state_nxt;
            if (rd_fire) rd_cnt <= rd_cnt + 1'b1;
            if (rd_last) rd_bank <= ~rd_bank;
        end
    end

    assign rd_word = mem[{rd_bank, rd_cnt}];

`ifdef FFT_OUT_REORDER_SCALE_EN
    logic signed [CW-1:0] re_s, im_s;
    // Divide each component by N, rounding toward -inf.
    always_comb begin
        re_s   = $signed(rd_word[DW-1:CW]) >>> LOG2N;
        im_s   = $signed(rd_word[CW-1:0]) >>> LOG2N;
        rd_out = {re_s, im_s};
    end
`else
    assign rd_out = rd_word;
`endif

    // Registered outputs; idle cycles drive zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_sop   <= 1'b0;
            bus.out_idx   <= '0;
            bus.out_data  <= '0;
        end else begin
            bus.out_valid <= rd_fire;
            bus.out_sop   <= rd_fire & (rd_cnt == '0);
            bus.out_idx   <= rd_fire ? rd_cnt : '0;
            bus.out_data  <= rd_fire ? rd_out : '0;
        end
    end
endmodule

// File: doc/fft_out_reorder.md
Name: fft_out_reorder

Overview:
- Streaming output stage placed directly downstream of fft_chip.
- fft_chip emits each 16-point frame in bit-reversed bin order, one complex sample per clock. This block buffers every frame in a ping-pong RAM and replays it in natural bin order (bin 0..N-1).
- It adds frame framing (out_sop) and a bin index, so later stages and benches need no external index arithmetic.

Parameters:
- DW, 34, sample width: {re[33:17], im[16:0]}; each 17-bit component is two's complement, 1 sign + 8 integer + 8 fraction bits.
- LOG2N, 4, log2 of frame length; N = 2**LOG2N = 16.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data carries a sample this cycle.
- in_sop  input  1  qualified by in_valid; marks the first sample of a frame.
- in_data  input  DW  FFT result sample, bit-reversed bin order within the frame.
- out_valid  output  1  out_data/out_idx valid this cycle.
- out_sop  output  1  high with the bin-0 sample of each output frame.
- out_idx  output  LOG2N  bin number of out_data.
- out_data  output  DW  reordered sample.
- sop_err  output  1  one-cycle pulse: in_sop arrived mid-frame.

Behaviour:
- Reset: async assert clears every output (out_valid, out_sop, sop_err = 0; out_idx, out_data = 0), both counters, both bank-full flags and the bank pointers. Clears the sync flag. RAM contents are not cleared. Reset mid-frame discards all partial and full banks.
- Storage: 2 banks x N words x DW; a 2N-word RAM addressed {bank, addr}.
- Sync: after reset, samples are ignored until the first in_valid & in_sop.
- Write side, per accepted sample (in_valid & synced):
  - store to {wr_bank, bitrev(wr_cnt)}, then increment wr_cnt.
  - in_sop resets the write to addr 0 with the current sample.
  - on the write with wr_cnt == N-1: set full[wr_bank], toggle wr_bank, wr_cnt wraps to 0.
- in_valid low: no write, counters hold. Gaps of any length are allowed.
- in_sop with wr_cnt != 0 (resync):
  - discard the partial frame; the current sample becomes addr 0 of the same bank.
  - pulse sop_err for 1 cycle, registered (high the cycle after).
- Read FSM:
  - IDLE: if full[rd_bank] -> READ, rd_cnt = 0.
  - READ: read {rd_bank, rd_cnt} sequentially; rd_cnt increments each cycle.
  - At rd_cnt == N-1: clear full[rd_bank] and toggle rd_bank. If the other bank is already full, stay in READ with no bubble; else go to IDLE.
- Outputs are registered:
  - out_valid high exactly N consecutive cycles per frame.
  - out_idx = rd_cnt delayed to align with the data.
  - out_sop = (out_idx == 0) & out_valid.
- Latency: last input sample accepted at edge t -> bin 0 on the outputs after edge t+1 (1-cycle turnaround). With continuous input, output is continuous at 1 sample/clock.
- No backpressure exists. Input rate never exceeds 1/clk, so a bank is always drained before it is rewritten.
- Write into a bank whose full flag is still set cannot occur by construction. The bench asserts it never happens.
- Simultaneous last-write and read-end on the same edge: the full-set (write bank) and the full-clear (read bank) target different banks, so both take effect.

Optional Feature:
- Macro FFT_OUT_REORDER_SCALE_EN.
- Defined: each 17-bit component of out_data is arithmetic-shifted right by LOG2N (divide by N, sign-extended, truncation toward -inf). Used for IFFT normalisation. Latency is unchanged.
- Undefined: out_data equals the stored sample bit-exactly.

Test Plan:
- Single frame: after rst_n high, feed 16 samples j=0..15 with re = bitrev(j)<<8, im = 0, in_sop at j=0 -> 1 cycle after the last input, out_valid high 16 cycles, out_idx 0..15, out_data.re = k<<8 (k = bin), out_sop only at k=0, sop_err stays 0.
- Back-to-back: 3 frames continuous, frame f re = (f<<12)|(bitrev(j)<<8) -> 48 contiguous out_valid cycles with no bubble; out_sop at cycles 0, 16, 32; values in natural order per frame.
- Gapped input: in_valid toggling 1,0,1,0 over one frame -> output unchanged from the single-frame case; out_valid starts 1 cycle after the 16th accepted sample.
- Resync: in_sop at j=0, 5 samples, then in_sop again followed by 16 clean samples -> sop_err pulses once; exactly one 16-sample output frame, matching the clean frame.
- Reset mid-output: assert rst_n=0 at output sample 7 -> out_valid, out_sop, out_idx, out_data are 0 immediately. After release, inputs without in_sop are ignored (out_valid stays 0) until a new in_sop frame arrives.
- With FFT_OUT_REORDER_SCALE_EN: input re = 17'h1_0000 (-256.0), im = 17'h0_1000 (16.0) at bin 3 -> out re = 17'h1_F000 (-16.0), im = 17'h0_0100 (1.0) at out_idx 3.
